mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: number of BUSY cycles without mem_ack before a bus error is declared (range 1..255).
REQ-002 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have `rst_n`, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have `MemtoRegM`, input, 1 bit: the instruction in MEM is a load.
REQ-005 SHALL have `MemWriteM`, input, 1 bit: the instruction in MEM is a store.
REQ-006 SHALL have `ALUOutM`, input, 32 bits: effective byte address.
REQ-007 SHALL have `WriteDataM`, input, 32 bits: unaligned store data; the value is in the low bits.
REQ-008 SHALL have `LoadTypeM`, input, 3 bits: 0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; codes 5-7 behave as LW.
REQ-009 SHALL have `SaveTypeM`, input, 2 bits: 0=SW, 1=SH, 2=SB; code 3 behaves as SW.
REQ-010 SHALL have `mem_rdata`, input, 32 bits: read word from data memory.
REQ-011 SHALL have `mem_ack`, input, 1 bit: memory completion, valid only while mem_req=1.
REQ-012 SHALL have `mem_req`, output, 1 bit, registered: memory request.
REQ-013 SHALL have `mem_we`, output, 1 bit, registered: write enable.
REQ-014 SHALL have `mem_addr`, output, 32 bits, registered: word address, with bits [1:0] always 0.
REQ-015 SHALL have `mem_be`, output, 4 bits, registered: byte enables; bit k selects byte lane [8k+7:8k].
REQ-016 SHALL have `mem_wdata`, output, 32 bits, registered: lane-replicated store data.
REQ-017 SHALL have `ReadDataM`, output, 32 bits, registered: extended load result.
REQ-018 SHALL have `StallM`, output, 1 bit, combinational: freezes the upstream pipeline registers.
REQ-019 SHALL have `AddrErrM`, output, 1 bit, registered: one-cycle pulse on a misaligned access.
REQ-020 SHALL have `BusErrM`, output, 1 bit, registered: one-cycle pulse on a timeout.

Function
REQ-021 SHALL define access = MemtoRegM | MemWriteM; if both are 1, the access SHALL be treated as a store.
REQ-022 SHALL treat an access as misaligned when it is W-type with ALUOutM[1:0]!=0, or H-type (LH/LHU/SH) with ALUOutM[0]!=0.
REQ-023 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-024 In IDLE with an aligned access, SHALL set at the next edge: mem_req=1, mem_we=store, mem_addr={ALUOutM[31:2],2'b00}, plus mem_be/mem_wdata; next state BUSY; timeout counter cleared.
REQ-025 In IDLE with a misaligned access, SHALL issue no request, pulse AddrErrM for one cycle, set ReadDataM=0, and go to DONE.
REQ-026 In IDLE with no access, SHALL stay in IDLE with ReadDataM held.
REQ-027 StallM SHALL be 1 in BUSY and in IDLE while access=1, and 0 in DONE and in IDLE with no access.
REQ-028 In BUSY with mem_ack=1, SHALL drop mem_req and mem_we at the next edge, capture the formatted load data into ReadDataM (loads only; stores hold ReadDataM), and go to DONE.
REQ-029 In BUSY with mem_ack=0, SHALL increment the counter; when it reaches TIMEOUT_CYCLES, SHALL drop mem_req, pulse BusErrM, set ReadDataM=0, and go to DONE.
REQ-030 DONE SHALL last exactly one cycle (StallM=0, so the pipeline advances) and then go to IDLE, evaluating the new instruction there.
REQ-031 Best-case latency SHALL be 3 cycles per access: issue, ack, DONE.
REQ-032 mem_addr, mem_be, mem_wdata and mem_we SHALL stay stable while mem_req=1.
REQ-033 Store lanes SHALL be:
- SW: be=1111, wdata=WriteDataM.
- SH: be=0011 if ALUOutM[1]=0, else 1100; wdata={2{WriteDataM[15:0]}}.
- SB: be=1<<ALUOutM[1:0]; wdata={4{WriteDataM[7:0]}}.
REQ-034 Loads SHALL use be=1111.
REQ-035 Loads SHALL select the lane from the issued address:
- LW: whole word.
- LH/LHU: half selected by addr[1], sign-/zero-extended.
- LB/LBU: byte selected by addr[1:0], sign-/zero-extended.
REQ-036 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-037 When rst_n=0 at a rising edge, SHALL force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, ReadDataM=0, AddrErrM=0, BusErrM=0, counter=0.
REQ-038 Reset asserted during BUSY SHALL abandon the access, with mem_req=0 from the next edge; no error pulse SHALL be generated.
REQ-039 StallM SHALL be 0 while in reset when access=0.

Verification
REQ-040 SB: ALUOutM=0x1003, WriteDataM=0xAB, ack 2 cycles after req -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1; StallM high 3 cycles, then 1 DONE cycle.
REQ-041 LB and LHU from mem_rdata=0x8081F2F3:
- LB at 0x2002 -> ReadDataM=0xFFFFFF81.
- LHU at 0x2002 -> ReadDataM=0x00008081.
REQ-042 LW at 0x3002 -> no mem_req, AddrErrM pulses 1 cycle, ReadDataM=0, StallM=0 on the next cycle.
REQ-043 Timeout: TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, BusErrM pulses once, ReadDataM=0.
REQ-044 Reset mid-BUSY -> mem_req=0 and state IDLE after the reset edge; a spurious mem_ack afterwards changes nothing.
REQ-045 Back-to-back SW then LW (same address 0x40, data 0x12345678) -> the LW returns 0x12345678; the second req issues in the cycle after DONE.

Source files
------------

// File: rtl/mem_access.sv
// Data-memory access unit: aligns stores, extends loads, and runs the memory handshake.
// Best case 3 cycles (issue, ack, done); holds the pipeline while a request is in flight.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  SaveTypeM,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AddrErrM,
  output logic        BusErrM
);

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [2:0]  ld_type;
  logic [1:0]  ld_off;
  logic        access;
  logic        word_acc;
  logic        half_acc;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  always_comb begin
    access   = MemtoRegM | MemWriteM;
    word_acc = 1'b0;
    half_acc = 1'b0;
    be       = 4'b1111;
    wdata    = WriteDataM;
    // A simultaneous load+store flag resolves to the store.
    if (MemWriteM) begin
      case (SaveTypeM)
        2'd1: begin
          half_acc = 1'b1;
          be       = ALUOutM[1] ? 4'b1100 : 4'b0011;
          wdata    = {2{WriteDataM[15:0]}};
        end
        2'd2: begin
          be    = 4'b0001 << ALUOutM[1:0];
          wdata = {4{WriteDataM[7:0]}};
        end
        default: word_acc = 1'b1;
      endcase
    end else begin
      case (LoadTypeM)
        3'd1, 3'd2: half_acc = 1'b1;
        3'd3, 3'd4: word_acc = 1'b0;
        default:    word_acc = 1'b1;
      endcase
    end
    misalign = word_acc ? (ALUOutM[1:0] != 2'b00) : (half_acc & ALUOutM[0]);
  end

  always_comb begin
    byte_sel = mem_rdata[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_type)
      3'd1:    load_fmt = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_fmt = {16'h0000, half_sel};
      3'd3:    load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_fmt = {24'h000000, byte_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  assign cnt_nxt = cnt + 8'd1;
  assign StallM  = rst_n & ((state == BUSY) | ((state == IDLE) & access));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      ReadDataM <= 32'h0;
      AddrErrM  <= 1'b0;
      BusErrM   <= 1'b0;
      cnt       <= 8'h0;
      ld_type   <= 3'h0;
      ld_off    <= 2'h0;
    end else begin
      AddrErrM <= 1'b0;
      BusErrM  <= 1'b0;
      case (state)
        IDLE: begin
          if (access && misalign) begin
            AddrErrM  <= 1'b1;
            ReadDataM <= 32'h0;
            state     <= DONE;
          end else if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUOutM[31:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wdata;
            ld_type   <= LoadTypeM;
            ld_off    <= ALUOutM[1:0];
            cnt       <= 8'h0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // mem_we still marks the in-flight access as a store; stores keep ReadDataM.
            if (!mem_we) ReadDataM <= load_fmt;
            state <= DONE;
          end else if (cnt_nxt == TIMEOUT) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            BusErrM   <= 1'b1;
            ReadDataM <= 32'h0;
            cnt       <= cnt_nxt;
            state     <= DONE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level expectation model plus literal pins.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic [2:0]  LoadTypeM;
  logic [1:0]  SaveTypeM;
  logic        mem_ack;
  logic        mem_req, mem_we, StallM, AddrErrM, BusErrM;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;
  logic [3:0]  mem_be;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .LoadTypeM(LoadTypeM),
    .SaveTypeM(SaveTypeM), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .ReadDataM(ReadDataM), .StallM(StallM),
    .AddrErrM(AddrErrM), .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic        exp_req = 0, exp_we = 0, exp_stall = 0, exp_aerr = 0, exp_berr = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rd = 0;
  logic [3:0]  exp_be = 0;

  int stalls, reqs, aerrs, berrs;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      chk("StallM", {31'b0, StallM}, {31'b0, exp_stall});
      chk("AddrErrM", {31'b0, AddrErrM}, {31'b0, exp_aerr});
      chk("BusErrM", {31'b0, BusErrM}, {31'b0, exp_berr});
      chk("ReadDataM", ReadDataM, exp_rd);
      if (exp_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  // Spec-level rules for alignment, lanes and load extension.
  function automatic logic mis(input logic st, input logic [2:0] lt, input logic [1:0] stt,
                               input logic [1:0] off);
    logic w, h;
    if (st) begin
      w = (stt == 2'd0) || (stt == 2'd3);
      h = (stt == 2'd1);
    end else begin
      w = (lt == 3'd0) || (lt >= 3'd5);
      h = (lt == 3'd1) || (lt == 3'd2);
    end
    return w ? (off != 2'd0) : (h && off[0]);
  endfunction

  function automatic logic [3:0] lanes(input logic st, input logic [1:0] stt, input logic [1:0] off);
    if (!st || stt == 2'd0 || stt == 2'd3) return 4'hf;
    if (stt == 2'd1) return off[1] ? 4'hc : 4'h3;
    return 4'h1 << off;
  endfunction

  function automatic logic [31:0] wrep(input logic st, input logic [1:0] stt, input logic [31:0] d);
    if (!st || stt == 2'd0 || stt == 2'd3) return d;
    if (stt == 2'd1) return (d & 32'hffff) * 32'h0001_0001;
    return (d & 32'hff) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hff;
    h = (w >> (16 * off[1])) & 32'hffff;
    case (lt)
      3'd1:    return (h ^ 32'h8000) - 32'h8000;
      3'd2:    return h;
      3'd3:    return (b ^ 32'h80) - 32'h80;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  task automatic cyc();
    #1;
    if (StallM === 1'b1) stalls++;
    if (mem_req === 1'b1) begin
      reqs++;
      last_addr  = mem_addr;
      last_be    = mem_be;
      last_wdata = mem_wdata;
      last_we    = mem_we;
    end
    if (AddrErrM === 1'b1) aerrs++;
    if (BusErrM === 1'b1) berrs++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ack);
    MemtoRegM = 0; MemWriteM = 0; mem_ack = ack;
    exp_stall = 0; exp_aerr = 0; exp_berr = 0;
    repeat (n) cyc();
    mem_ack = 0;
  endtask

  // One access from its IDLE cycle through DONE; ack_at is the BUSY cycle index of the ack, -1 for none.
  task automatic run(input logic ld, input logic st, input logic [2:0] lt, input logic [1:0] stt,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                     input int ack_at);
    logic acked;
    MemtoRegM = ld; MemWriteM = st; ALUOutM = a; WriteDataM = d;
    LoadTypeM = lt; SaveTypeM = stt; mem_rdata = rd; mem_ack = 0;
    stalls = 0; reqs = 0; aerrs = 0; berrs = 0;
    exp_aerr = 0; exp_berr = 0; exp_stall = 1;
    cyc();
    if (mis(st, lt, stt, a[1:0])) begin
      exp_aerr = 1; exp_rd = 0; exp_stall = 0;
      cyc();
      return;
    end
    exp_req = 1; exp_we = st; exp_addr = a & ~32'h3;
    exp_be = lanes(st, stt, a[1:0]); exp_wdata = wrep(st, stt, d);
    acked = 0;
    for (int k = 0; k < TO; k++) begin
      mem_ack = (k == ack_at);
      cyc();
      if (k == ack_at) begin
        acked = 1;
        break;
      end
    end
    mem_ack = 0; exp_req = 0; exp_we = 0; exp_stall = 0;
    if (acked) begin
      if (!st) exp_rd = fmt(lt, a[1:0], rd);
    end else begin
      exp_berr = 1; exp_rd = 0;
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 0; MemtoRegM = 0; MemWriteM = 0; ALUOutM = 0; WriteDataM = 0;
    LoadTypeM = 0; SaveTypeM = 0; mem_rdata = 0; mem_ack = 0;
    @(posedge clk); #1;
    chk_en = 1;
    cyc();
    rst_n = 1;
    idle(2, 1'b0);

    // SB at 0x1003, ack in second BUSY cycle
    run(0, 1, 3'd0, 2'd2, 32'h1003, 32'hAB, 32'h0, 1);
    chk("sb_addr", last_addr, 32'h1000);
    chk("sb_be", {28'b0, last_be}, 32'h8);
    chk("sb_wdata", last_wdata, 32'hABABABAB);
    chk("sb_we", {31'b0, last_we}, 32'h1);
    chk("sb_stall_cycles", stalls, 3);
    idle(1, 1'b0);

    run(1, 0, 3'd3, 2'd0, 32'h2002, 32'h0, 32'h8081F2F3, 0);
    chk("lb_rd", ReadDataM, 32'hFFFFFF81);
    run(1, 0, 3'd2, 2'd0, 32'h2002, 32'h0, 32'h8081F2F3, 0);
    chk("lhu_rd", ReadDataM, 32'h00008081);

    run(1, 0, 3'd0, 2'd0, 32'h3002, 32'h0, 32'h0, 0);
    chk("lw_mis_rd", ReadDataM, 32'h0);
    chk("lw_mis_aerr", aerrs, 1);
    chk("lw_mis_req", reqs, 0);

    run(0, 1, 3'd0, 2'd1, 32'h2006, 32'h1234BEEF, 32'h0, 0);
    chk("sh_be", {28'b0, last_be}, 32'hC);
    run(1, 0, 3'd1, 2'd0, 32'h0012, 32'h0, 32'h80001234, 1);
    chk("lh_rd", ReadDataM, 32'hFFFF8000);
    run(1, 0, 3'd4, 2'd0, 32'h0011, 32'h0, 32'h0000F280, 0);
    run(0, 1, 3'd0, 2'd1, 32'h2001, 32'h5555, 32'h0, 0);
    run(1, 1, 3'd3, 2'd2, 32'h0005, 32'h77, 32'h0, 2);
    chk("both_be", {28'b0, last_be}, 32'h2);

    run(1, 0, 3'd0, 2'd0, 32'h0100, 32'h0, 32'hDEADBEEF, -1);
    chk("to_reqs", reqs, 4);
    chk("to_berr", berrs, 1);
    chk("to_rd", ReadDataM, 32'h0);

    // reset during BUSY
    MemtoRegM = 1; MemWriteM = 0; ALUOutM = 32'h80; LoadTypeM = 3'd0; mem_ack = 0;
    exp_berr = 0; exp_aerr = 0; exp_stall = 1;
    cyc();
    exp_req = 1; exp_we = 0; exp_addr = 32'h80; exp_be = 4'hf; exp_wdata = WriteDataM;
    cyc();
    rst_n = 0; MemtoRegM = 0; exp_stall = 0;
    cyc();
    exp_req = 0; exp_we = 0; exp_rd = 0;
    berrs = 0; aerrs = 0;
    cyc();
    rst_n = 1;
    idle(3, 1'b1);
    chk("rst_no_err", berrs + aerrs, 0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);

    run(0, 1, 3'd0, 2'd0, 32'h40, 32'h12345678, 32'h0, 0);
    chk("sw_wdata", last_wdata, 32'h12345678);
    run(1, 0, 3'd0, 2'd0, 32'h40, 32'h0, 32'h12345678, 2);
    chk("lw_rd", ReadDataM, 32'h12345678);
    chk("lw_stall_cycles", stalls, 4);
    run(1, 0, 3'd7, 2'd0, 32'h44, 32'h0, 32'hCAFEF00D, 0);
    chk("lt7_rd", ReadDataM, 32'hCAFEF00D);
    idle(2, 1'b0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
